// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock FIFO with occupancy count, almost thresholds, sticky errors
// Read mode is selected by FWFT: registered rdata on ren, or first-word-fall-through.
module sync_fifo_fwft #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow,
  input  logic                err_clr
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] LP_DEPTH  = DEPTH[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] LP_AFULL  = AFULL_TH[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] LP_AEMPTY = AEMPTY_TH[ADDRSIZE:0];

  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [ADDRSIZE:0]   r_wptr;
  logic [ADDRSIZE:0]   r_rptr;
  logic [ADDRSIZE:0]   r_count;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_full;
  logic                w_empty;
  logic                w_wen;
  logic                w_ren;
  logic [ADDRSIZE-1:0] w_waddr;
  logic [ADDRSIZE-1:0] w_raddr;

  // Flags come only from the registered count, so no winc/rinc path reaches them.
  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_wen   = winc & ~w_full;
  assign w_ren   = rinc & ~w_empty;
  assign w_waddr = r_wptr[ADDRSIZE-1:0];
  assign w_raddr = r_rptr[ADDRSIZE-1:0];

  always_ff @(posedge clk) begin
    if (w_wen) r_mem[w_waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wen) r_wptr <= r_wptr + 1'b1;
      if (w_ren) r_rptr <= r_rptr + 1'b1;
      if (w_wen && !w_ren)      r_count <= r_count + 1'b1;
      else if (w_ren && !w_wen) r_count <= r_count - 1'b1;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (winc && w_full)  r_overflow <= 1'b1;
      else if (err_clr)    r_overflow <= 1'b0;
      if (rinc && w_empty) r_underflow <= 1'b1;
      else if (err_clr)    r_underflow <= 1'b0;
    end
  end

  // Occupancy must always equal the wrap-aware pointer distance.
  always_ff @(posedge clk) begin
    if (!rst) assert (r_count == r_wptr - r_rptr);
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = w_empty ? '0 : r_mem[w_raddr];
    end else begin : g_std
      logic [DATASIZE-1:0] r_rdata;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_rdata <= '0;
        else if (w_ren) r_rdata <= r_mem[w_raddr];
      end
      assign rdata = r_rdata;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= LP_AFULL);
  assign almost_empty = (r_count <= LP_AEMPTY);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb/tb_sync_fifo_fwft.sv - checks standard and FWFT instances against a queue-based reference model
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic       err_clr;

  logic [7:0] s_rdata, f_rdata;
  logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q[$];
  logic       m_ovf;
  logic       m_udf;
  logic [7:0] m_srd;
  logic [7:0] dval;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2)) u_std (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(s_rdata),
    .full(s_full), .empty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf), .err_clr(err_clr));

  sync_fifo_fwft #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(2)) u_fwft (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(f_rdata),
    .full(f_full), .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_srd = 8'h00;
  endtask

  task automatic model_edge(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit was_full, was_empty;
    was_full  = (m_q.size() == 16);
    was_empty = (m_q.size() == 0);
    if (r && !was_empty) m_srd = m_q.pop_front();
    if (w && !was_full)  m_q.push_back(d);
    if (w && was_full)   m_ovf = 1'b1;
    else if (c)          m_ovf = 1'b0;
    if (r && was_empty)  m_udf = 1'b1;
    else if (c)          m_udf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".count"},  32'(s_count),  32'(n));
    chk({tag, ".fcount"}, 32'(f_count),  32'(n));
    chk({tag, ".empty"},  32'(s_empty),  32'(n == 0));
    chk({tag, ".fempty"}, 32'(f_empty),  32'(n == 0));
    chk({tag, ".full"},   32'(s_full),   32'(n == 16));
    chk({tag, ".ffull"},  32'(f_full),   32'(n == 16));
    chk({tag, ".afull"},  32'(s_afull),  32'(n >= 12));
    chk({tag, ".faful"},  32'(f_afull),  32'(n >= 12));
    chk({tag, ".aempty"}, 32'(s_aempty), 32'(n <= 2));
    chk({tag, ".faemp"},  32'(f_aempty), 32'(n <= 2));
    chk({tag, ".ovf"},    32'(s_ovf),    32'(m_ovf));
    chk({tag, ".fovf"},   32'(f_ovf),    32'(m_ovf));
    chk({tag, ".udf"},    32'(s_udf),    32'(m_udf));
    chk({tag, ".fudf"},   32'(f_udf),    32'(m_udf));
    chk({tag, ".srdata"}, 32'(s_rdata),  32'(m_srd));
    if (n > 0) chk({tag, ".frdata"}, 32'(f_rdata), 32'(m_q[0]));
  endtask

  task automatic step(input string tag, input logic w, input logic [7:0] d, input logic r, input logic c);
    winc = w; wdata = d; rinc = r; err_clr = c;
    @(posedge clk);
    model_edge(w, d, r, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; wdata = 8'h00; rinc = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.frdata0", 32'(f_rdata), 32'h0);
    rst = 1'b0;
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("wr17", 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("wr17.ovf", 32'(s_ovf), 32'h1);
    chk("wr17.cnt", 32'(s_count), 32'd16);

    for (int i = 0; i < 16; i++) begin
      step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain.val", 32'(s_rdata), 32'(i));
    end
    step("rdextra", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rdextra.udf", 32'(s_udf), 32'h1);
    chk("rdextra.hold", 32'(s_rdata), 32'h0F);
    step("clr", 1'b0, 8'h00, 1'b0, 1'b1);

    dval = 8'h40;
    for (int i = 0; i < 8; i++) begin step("half", 1'b1, dval, 1'b0, 1'b0); dval++; end
    for (int i = 0; i < 40; i++) begin
      step("rw", 1'b1, dval, 1'b1, 1'b0);
      chk("rw.cnt8", 32'(s_count), 32'd8);
      dval++;
    end
    for (int i = 0; i < 8; i++) step("half_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    step("fwft_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft.rdata", 32'(f_rdata), 32'hA5);
    chk("fwft.empty", 32'(f_empty), 32'h0);
    step("fwft_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    step("fwft_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft.empty_after", 32'(f_empty), 32'h1);

    for (int i = 0; i < 17; i++) step("refill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step("to5", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst.cnt", 32'(s_count), 32'd5);
    chk("pre_rst.ovf", 32'(s_ovf), 32'h1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("held_rst");
    rst = 1'b0;
    step("post_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("post_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post.rdata", 32'(s_rdata), 32'h3C);

    step("udf_set", 1'b0, 8'h00, 1'b1, 1'b0);
    step("udf_setwins", 1'b0, 8'h00, 1'b1, 1'b1);
    chk("setwins.udf", 32'(s_udf), 32'h1);
    for (int i = 0; i < 3; i++) step("three", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step("errclr", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("errclr.udf", 32'(s_udf), 32'h0);
    chk("errclr.cnt", 32'(s_count), 32'd3);

    for (int i = 0; i < 450; i++) begin
      int wp;
      wp = (i < 150) ? 75 : (i < 300) ? 25 : 50;
      step("rand", ($urandom_range(99) < wp), 8'($urandom), ($urandom_range(99) >= wp),
           ($urandom_range(9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
